// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub datapath among NREQ requesters
// Optional overflow output res_ovf is built when ADDSUB_ARB_OVF_EN is defined.
`timescale 1ns/1ps

module addsub_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  input  logic [NREQ-1:0]         req_sign,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_z,
  output logic [IDW-1:0]          res_id
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic                    res_ovf
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] res_z_q, res_z_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic [IDW-1:0]   hi_id, lo_id, grant_id;
  logic             hi_found, grant_any;
  logic             can_accept, xfer;
  logic [WIDTH-1:0] x_sel, y_sel, z_calc;
  logic             sign_sel;

`ifdef ADDSUB_ARB_OVF_EN
  logic             res_ovf_q, res_ovf_d;
  logic             ovf_calc;
`endif

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid overall (wrap).
  always_comb begin
    hi_id     = '0;
    lo_id     = '0;
    hi_found  = 1'b0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_id     = IDW'(i);
        grant_any = 1'b1;
        if (IDW'(i) >= rr_ptr_q) begin
          hi_id    = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant_id = hi_found ? hi_id : lo_id;
  end

  // Operand mux: route the winning requester's operands into the shared adder.
  always_comb begin
    x_sel    = '0;
    y_sel    = '0;
    sign_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        x_sel    = req_x[i*WIDTH +: WIDTH];
        y_sel    = req_y[i*WIDTH +: WIDTH];
        sign_sel = req_sign[i];
      end
    end
  end

  // Shared add/subtract datapath; result wraps modulo 2**WIDTH.
  always_comb begin
    z_calc = sign_sel ? (x_sel - y_sel) : (x_sel + y_sel);
  end

`ifdef ADDSUB_ARB_OVF_EN
  // Signed overflow: add needs equal operand signs, subtract needs differing ones; then result sign flips from x.
  always_comb begin
    ovf_calc = (z_calc[WIDTH-1] != x_sel[WIDTH-1]) &&
               (sign_sel ? (x_sel[WIDTH-1] != y_sel[WIDTH-1])
                         : (x_sel[WIDTH-1] == y_sel[WIDTH-1]));
  end
`endif

  // FSM outputs: one-hot ready for the winner when the result slot can take a new value.
  always_comb begin
    can_accept = (state_q == IDLE) || res_ready;
    res_valid  = (state_q == HOLD);
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && grant_any && can_accept && (grant_id == IDW'(i));
    end
    xfer = |(req_valid & req_ready);
  end

  // FSM next state: a grant always (re)fills the slot; a retire without grant empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer) state_d = HOLD;
      HOLD: begin
        if (xfer)           state_d = HOLD;
        else if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load result and advance priority only on a transfer.
  always_comb begin
    res_z_d  = res_z_q;
    res_id_d = res_id_q;
    rr_ptr_d = rr_ptr_q;
`ifdef ADDSUB_ARB_OVF_EN
    res_ovf_d = res_ovf_q;
`endif
    if (xfer) begin
      res_z_d  = z_calc;
      res_id_d = grant_id;
      rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
`ifdef ADDSUB_ARB_OVF_EN
      res_ovf_d = ovf_calc;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and priority registers; a reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_z_q  <= '0;
      res_id_q <= '0;
      rr_ptr_q <= '0;
`ifdef ADDSUB_ARB_OVF_EN
      res_ovf_q <= 1'b0;
`endif
    end else begin
      res_z_q  <= res_z_d;
      res_id_q <= res_id_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ADDSUB_ARB_OVF_EN
      res_ovf_q <= res_ovf_d;
`endif
    end
  end

  assign res_z  = res_z_q;
  assign res_id = res_id_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter with a behavioural model
`timescale 1ns/1ps

module tb_addsub_arbiter;

  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int MOD  = 1 << W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_x;
  logic [NREQ*W-1:0]     req_y;
  logic [NREQ-1:0]       req_sign;
  logic                  res_valid;
  logic                  res_ready;
  logic [W-1:0]          res_z;
  logic [IDW-1:0]        res_id;
`ifdef ADDSUB_ARB_OVF_EN
  logic                  res_ovf;
`endif

  addsub_arbiter #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sign  (req_sign),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_id    (res_id)
`ifdef ADDSUB_ARB_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: result slot, tag, priority pointer.
  int         m_rr    = 0;
  logic       m_valid = 1'b0;
  logic [W-1:0] m_z   = '0;
  int         m_id    = 0;
  logic       m_ovf   = 1'b0;

  function automatic int mgrant();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_rr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g, x, y, r, sx, sy, tr;
    if (rst) begin
      m_rr = 0; m_valid = 1'b0; m_z = '0; m_id = 0; m_ovf = 1'b0;
    end else begin
      g = mgrant();
      if (g >= 0 && (!m_valid || res_ready)) begin
        x  = int'(req_x[g*W +: W]);
        y  = int'(req_y[g*W +: W]);
        r  = req_sign[g] ? (x - y) : (x + y);
        m_z = W'(((r % MOD) + MOD) % MOD);
        sx = (x >= MOD/2) ? x - MOD : x;
        sy = (y >= MOD/2) ? y - MOD : y;
        tr = req_sign[g] ? (sx - sy) : (sx + sy);
        m_ovf   = (tr > MOD/2 - 1) || (tr < -(MOD/2));
        m_valid = 1'b1;
        m_id    = g;
        m_rr    = (g + 1) % NREQ;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] want_ready;
    if (started) begin
      g = mgrant();
      want_ready = '0;
      if (!rst && g >= 0 && (!m_valid || res_ready)) want_ready[g] = 1'b1;
      chk("model_req_ready", req_ready, want_ready);
      chk("model_res_valid", res_valid, m_valid);
      chk("model_res_z", res_z, m_z);
      chk("model_res_id", res_id, m_id);
`ifdef ADDSUB_ARB_OVF_EN
      chk("model_res_ovf", res_ovf, m_ovf);
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
    req_sign[i]     = s;
  endtask

  logic [W-1:0] exp_z [NREQ] = '{8'd12, 8'd21, 8'd46, 8'd51};

  initial begin
    rst = 1'b1; req_valid = '1; res_ready = 1'b0;
    req_x = '0; req_y = '0; req_sign = '0;

    // Reset: ready forced low even with all requests valid.
    next_cycle(); started = 1'b1;
    settle(); chk("rst_ready_zero", req_ready, 4'b0000);
    next_cycle(); rst = 1'b0; req_valid = '0; res_ready = 1'b1;
    settle();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_z", res_z, 8'd0);
    chk("rst_id", res_id, 2'd0);

    // Single add on requester 2.
    next_cycle(); set_op(2, 8'd5, 8'd7, 1'b0); req_valid = 4'b0100;
    settle(); chk("t1_ready", req_ready, 4'b0100);
    next_cycle(); req_valid = '0;
    settle();
    chk("t1_valid", res_valid, 1'b1);
    chk("t1_z", res_z, 8'd12);
    chk("t1_id", res_id, 2'd2);

    // Subtract wrap, then signed-overflow add.
    next_cycle(); set_op(0, 8'd3, 8'd5, 1'b1); req_valid = 4'b0001;
    settle(); chk("t2_ready0", req_ready, 4'b0001);
    next_cycle(); set_op(1, 8'h7F, 8'h01, 1'b0); req_valid = 4'b0010;
    settle();
    chk("t2_sub_z", res_z, 8'hFE);
    chk("t2_sub_id", res_id, 2'd0);
    chk("t2_ready1", req_ready, 4'b0010);
`ifdef ADDSUB_ARB_OVF_EN
    chk("t2_sub_ovf", res_ovf, 1'b0);
`endif
    next_cycle(); req_valid = '0;
    settle();
    chk("t2_add_z", res_z, 8'h80);
    chk("t2_add_id", res_id, 2'd1);
`ifdef ADDSUB_ARB_OVF_EN
    chk("t2_add_ovf", res_ovf, 1'b1);
`endif
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;

    // Round-robin with all requesters valid: 0,1,2,3,0,1,2,3 with no bubbles.
    next_cycle();
    for (int i = 0; i < NREQ; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      set_op(i, 8'(16*i + 9), 8'(i + 3), iv[0]);
    end
    req_valid = 4'b1111;
    settle(); chk("t3_first_ready", req_ready, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 8) req_valid = '0;
      settle();
      chk("t3_valid", res_valid, 1'b1);
      chk("t3_id", res_id, 32'((k - 1) % 4));
      chk("t3_z", res_z, exp_z[(k - 1) % 4]);
    end

    // Backpressure for 5 cycles, then resume at the requester after the last winner.
    next_cycle(); set_op(0, 8'hC8, 8'h64, 1'b0); req_valid = 4'b0001;
    settle(); chk("t4_ready0", req_ready, 4'b0001);
    next_cycle(); res_ready = 1'b0; req_valid = 4'b0011; set_op(1, 8'h10, 8'h20, 1'b1);
    settle();
    chk("t4_bp_ready", req_ready, 4'b0000);
    chk("t4_bp_z", res_z, 8'h2C);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      settle();
      chk("t4_hold_ready", req_ready, 4'b0000);
      chk("t4_hold_z", res_z, 8'h2C);
      chk("t4_hold_id", res_id, 2'd0);
      chk("t4_hold_valid", res_valid, 1'b1);
    end
    next_cycle(); res_ready = 1'b1;
    settle(); chk("t4_resume_ready", req_ready, 4'b0010);
    next_cycle(); req_valid = '0;
    settle();
    chk("t4_resume_id", res_id, 2'd1);
    chk("t4_resume_z", res_z, 8'hF0);

    // Idle cycles must not rotate priority.
    next_cycle(); set_op(1, 8'd1, 8'd1, 1'b0); req_valid = 4'b0010;
    settle(); chk("t5_ready1", req_ready, 4'b0010);
    next_cycle(); req_valid = '0;
    settle(); chk("t5_z", res_z, 8'd2);
    repeat (3) begin
      next_cycle();
      settle();
    end
    next_cycle(); set_op(0, 8'd4, 8'd4, 1'b1); req_valid = 4'b0011;
    settle(); chk("t5_wrap_ready0", req_ready, 4'b0001);
    next_cycle();
    settle();
    chk("t5_then_ready1", req_ready, 4'b0010);
    chk("t5_id0", res_id, 2'd0);
    chk("t5_z0", res_z, 8'd0);
    next_cycle(); req_valid = '0;
    settle(); chk("t5_id1", res_id, 2'd1);

    // Reset while a result is held under backpressure.
    next_cycle(); set_op(2, 8'h55, 8'h11, 1'b1); req_valid = 4'b0100;
    settle(); chk("t6_ready2", req_ready, 4'b0100);
    next_cycle(); req_valid = '0; res_ready = 1'b0;
    settle();
    chk("t6_held_z", res_z, 8'h44);
    chk("t6_held_valid", res_valid, 1'b1);
    next_cycle(); rst = 1'b1; req_valid = 4'b1000; set_op(3, 8'h80, 8'h80, 1'b0);
    settle(); chk("t6_rst_ready", req_ready, 4'b0000);
    next_cycle(); rst = 1'b0;
    settle();
    chk("t6_post_valid", res_valid, 1'b0);
    chk("t6_post_z", res_z, 8'd0);
    chk("t6_post_id", res_id, 2'd0);
    chk("t6_post_ready", req_ready, 4'b1000);
    next_cycle(); req_valid = '0; res_ready = 1'b1;
    settle();
    chk("t6_new_valid", res_valid, 1'b1);
    chk("t6_new_id", res_id, 2'd3);
    chk("t6_new_z", res_z, 8'd0);
`ifdef ADDSUB_ARB_OVF_EN
    chk("t6_new_ovf", res_ovf, 1'b1);
`endif
    next_cycle();
    settle();
    chk("t6_drain_valid", res_valid, 1'b0);
    chk("t6_drain_id", res_id, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one add/subtract datapath, WIDTH bits wide, among NREQ requesters.
- Each requester presents operands x, y and a sign bit over a valid/ready handshake.
- The block grants one requester per cycle, computes z = sign ? x-y : x+y, and returns a registered result tagged with the requester index.
- It sits between the ALU-level clients and the shared add_sub resource.

Parameters:
- WIDTH, 8: operand and result width in bits.
- NREQ, 4: number of requesters, legal range 2..16.
- IDW, 2: width of the requester-index tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_x  input  NREQ*WIDTH  packed operand x; requester i uses bits [i*WIDTH +: WIDTH].
- req_y  input  NREQ*WIDTH  packed operand y; same packing as req_x.
- req_sign  input  NREQ  1 = subtract, 0 = add.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accept.
- res_z  output  WIDTH  result.
- res_id  output  IDW  index of the requester that produced res_z.

Behaviour:
- Reset:
  - rst is sampled only on a clk edge.
  - Reset values: res_valid=0, res_z=0, res_id=0, rr_ptr=0, state=IDLE.
  - req_ready is combinational but forced to 0 while rst=1.
- States:
  - IDLE: no result held.
  - HOLD: result register occupied.
- Transitions:
  - IDLE -> HOLD when any grant occurs.
  - HOLD -> IDLE when res_ready=1 and no new grant occurs that cycle.
  - HOLD -> HOLD when res_ready=0, or when res_ready=1 and a new grant occurs.
- Accept condition: can_accept = (state==IDLE) || res_ready.
- Arbitration:
  - Search req_valid starting at index rr_ptr, ascending, wrapping from NREQ-1 to 0.
  - The first set bit wins.
  - req_ready[g] = can_accept for the winner g; all other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and res_ready.
- Transfer: occurs on requester g when req_valid[g] && req_ready[g] at a clk edge. On that edge:
  - res_z <= sign ? (x - y) : (x + y), truncated to WIDTH bits (modulo 2**WIDTH, two's-complement wrap, no saturation).
  - res_id <= g.
  - res_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- Latency and throughput:
  - Result is visible exactly 1 cycle after acceptance.
  - Sustained throughput is 1 operation per cycle while res_ready=1.
- Backpressure:
  - While res_valid=1 and res_ready=0: res_z, res_id and res_valid hold stable, and all req_ready are 0.
  - Requesters must hold their x, y and sign stable while valid and not ready.
- Simultaneous events:
  - res_ready=1 with a new grant in the same cycle: the old result retires and the new result loads; res_valid stays 1 with no bubble.
  - res_ready=1 with no grant: res_valid <= 0. res_z and res_id keep their last values.
- rr_ptr changes only on a transfer. Idle cycles do not rotate priority.
- Reset mid-operation: any held result is discarded. No response is produced for a request accepted in the cycle rst is high, because req_ready=0 during reset.
- Unused tag values (NREQ < 2**IDW) never appear on res_id.

Optional Feature:
- Macro: ADDSUB_ARB_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit, reset 0), registered together with res_z.
  - res_ovf = signed two's-complement overflow of the operation:
    - add: operands have the same sign and the result sign differs.
    - sub: operands have different signs and the result sign differs from x.
- Not defined:
  - The port is absent and no overflow logic is built.
  - All other behaviour is identical.

Test Plan:
1. Single add: WIDTH=8, after reset, req 2 valid, x=8'd5, y=8'd7, sign=0, res_ready=1 -> req_ready=4'b0100 that cycle; next cycle res_valid=1, res_z=8'd12, res_id=2.
2. Subtract wrap: req 0, x=8'd3, y=8'd5, sign=1 -> res_z=8'hFE, res_id=0. With ADDSUB_ARB_OVF_EN, res_ovf=0. Separately, x=8'h7F, y=8'h01, sign=0 -> res_z=8'h80, res_ovf=1.
3. Round-robin fairness: req_valid=4'b1111 held for 8 cycles, res_ready=1 -> grant order 0,1,2,3,0,1,2,3; res_valid continuously 1 from cycle 1; no bubbles.
4. Backpressure: result pending, res_ready=0 for 5 cycles, req_valid=4'b0011 -> req_ready=0, res_z and res_id stable. When res_ready rises, the next grant goes to the index after the last winner, and the new result appears the following cycle.
5. Idle no-rotate: grant req 1, then 3 idle cycles, then req_valid=4'b0011 -> requester 0 is not favoured because rr_ptr=2; the search wraps and grants 0 first, then 1.
6. Reset mid-stream: res_valid=1 and res_ready=0, assert rst for 1 cycle -> after the edge res_valid=0, res_z=0, res_id=0, rr_ptr=0; req_ready=0 during rst; next req_valid=4'b1000 is granted normally.
